// File: rtl/load_store_unit_if.sv
// Request/response and byte-memory signals of the load/store unit.
// slave = the unit itself; master = pipeline plus data memory.
interface load_store_unit_if #(
   parameter int unsigned ADDR_W = 64
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [63:0]       req_wdata;
   logic              resp_valid;
   logic              resp_err;
   logic [63:0]       resp_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic              mem_re;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_err, resp_rdata,
             mem_addr, mem_we, mem_re, mem_wdata
   );

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_err, resp_rdata,
             mem_addr, mem_we, mem_re, mem_wdata
   );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: sequences each request as 1/2/4/8 little-endian
// byte accesses and returns sign/zero-extended load data.
module load_store_unit #(
   parameter int unsigned ADDR_W = 64
) (
   input logic              clk,
   input logic              reset,
   load_store_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] base_q;
   logic [63:0]       wdata_q, shreg_q, hold_q, ext, wsh;
   logic [2:0]        funct3_q, idx_q, size_m1;
   logic              write_q, err_q, illegal, last;

   assign illegal = bus.req_write ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
   assign size_m1 = 3'((4'd1 << funct3_q[1:0]) - 4'd1);
   assign last    = (idx_q == size_m1);
   assign wsh     = wdata_q >> {idx_q, 3'b000};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.req_ready = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_err  = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_we    = 1'b0;
      bus.mem_re    = 1'b0;
      bus.mem_wdata = '0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_nxt = illegal ? DONE : XFER;
         end
         XFER: begin
            bus.mem_addr  = base_q + ADDR_W'(idx_q);
            bus.mem_we    = write_q;
            bus.mem_re    = !write_q;
            bus.mem_wdata = wsh[7:0];
            if (last) state_nxt = DONE;
         end
         DONE: begin
            bus.resp_valid = 1'b1;
            bus.resp_err   = err_q;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ext = '0;
      if (!write_q && !err_q) begin
         case (funct3_q)
            3'b000:  ext = {{56{shreg_q[7]}},  shreg_q[7:0]};
            3'b001:  ext = {{48{shreg_q[15]}}, shreg_q[15:0]};
            3'b010:  ext = {{32{shreg_q[31]}}, shreg_q[31:0]};
            3'b011:  ext = shreg_q;
            3'b100:  ext = {56'd0, shreg_q[7:0]};
            3'b101:  ext = {48'd0, shreg_q[15:0]};
            3'b110:  ext = {32'd0, shreg_q[31:0]};
            default: ext = '0;
         endcase
      end
   end

   // Response data is live from the assembled bytes in DONE, then held.
   assign bus.resp_rdata = (state == DONE) ? ext : hold_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_q   <= '0;
         wdata_q  <= '0;
         shreg_q  <= '0;
         hold_q   <= '0;
         funct3_q <= '0;
         idx_q    <= '0;
         write_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  base_q   <= bus.req_addr;
                  wdata_q  <= bus.req_wdata;
                  funct3_q <= bus.req_funct3;
                  write_q  <= bus.req_write;
                  err_q    <= illegal;
                  idx_q    <= '0;
                  shreg_q  <= '0;
               end
            end
            XFER: begin
               if (!write_q) shreg_q[{idx_q, 3'b000} +: 8] <= bus.mem_rdata;
               idx_q <= idx_q + 3'd1;
            end
            DONE:    hold_q <= ext;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a 256-byte memory model.
module tb_load_store_unit;
   logic clk = 1'b0;
   logic reset;
   logic preload;
   logic [7:0] mem [256];
   logic [7:0] img [256];
   int n_chk = 0;
   int n_pass = 0;

   load_store_unit_if #(.ADDR_W(64)) bus ();
   load_store_unit #(.ADDR_W(64)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (preload) mem <= img;
      else if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
   end
   assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

   typedef struct {
      logic        wr;
      logic [2:0]  f3;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      logic        err;
      int unsigned lat;
   } vec_t;

   vec_t vecs [20];

   task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
   endtask

   task automatic run(input int idx, input vec_t v);
      logic [63:0] sh;
      chk("ready_before", idx, 64'(bus.req_ready), 64'd1);
      bus.req_valid  = 1'b1;
      bus.req_write  = v.wr;
      bus.req_funct3 = v.f3;
      bus.req_addr   = v.addr;
      bus.req_wdata  = v.wdata;
      @(negedge clk);
      bus.req_valid = 1'b0;
      for (int unsigned c = 1; c <= v.lat; c++) begin
         if (c < v.lat) begin
            chk("busy_ready", idx, 64'(bus.req_ready), 64'd0);
            chk("busy_resp",  idx, 64'(bus.resp_valid), 64'd0);
            chk("mem_we",     idx, 64'(bus.mem_we), 64'(v.wr));
            chk("mem_re",     idx, 64'(bus.mem_re), 64'(!v.wr));
            chk("mem_addr",   idx, bus.mem_addr, v.addr + 64'(c - 1));
            if (v.wr) begin
               sh = v.wdata >> (8 * (c - 1));
               chk("mem_wdata", idx, 64'(bus.mem_wdata), 64'(sh[7:0]));
            end
         end else begin
            chk("resp_valid", idx, 64'(bus.resp_valid), 64'd1);
            chk("resp_err",   idx, 64'(bus.resp_err), 64'(v.err));
            chk("resp_rdata", idx, bus.resp_rdata, v.rdata);
            chk("done_we",    idx, 64'(bus.mem_we | bus.mem_re), 64'd0);
         end
         @(negedge clk);
      end
      chk("resp_pulse", idx, 64'(bus.resp_valid), 64'd0);
      chk("rdata_hold", idx, bus.resp_rdata, v.rdata);
   endtask

   initial begin
      logic [7:0] exp_bytes [8];
      vec_t fin;
      for (int i = 0; i < 256; i++) img[i] = 8'h00;
      img[20] = 8'h09; img[30] = 8'h80;
      img[50] = 8'h34; img[51] = 8'h92; img[52] = 8'h78;
      img[53] = 8'h56; img[54] = 8'h34; img[55] = 8'hF2;
      img[252] = 8'h01; img[253] = 8'h02; img[254] = 8'h03; img[255] = 8'h04;
      img[0] = 8'h05; img[1] = 8'h06; img[2] = 8'h07; img[3] = 8'h08;

      //         wr    f3      addr                   wdata                  rdata                  err lat
      vecs[0]  = '{1'b0, 3'b011, 64'd20,               64'd0,                 64'd9,                 1'b0, 9};
      vecs[1]  = '{1'b0, 3'b000, 64'd30,               64'd0,                 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2};
      vecs[2]  = '{1'b0, 3'b100, 64'd30,               64'd0,                 64'h0000_0000_0000_0080, 1'b0, 2};
      vecs[3]  = '{1'b0, 3'b001, 64'd50,               64'd0,                 64'hFFFF_FFFF_FFFF_9234, 1'b0, 3};
      vecs[4]  = '{1'b0, 3'b101, 64'd50,               64'd0,                 64'h0000_0000_0000_9234, 1'b0, 3};
      vecs[5]  = '{1'b0, 3'b010, 64'd52,               64'd0,                 64'hFFFF_FFFF_F234_5678, 1'b0, 5};
      vecs[6]  = '{1'b0, 3'b110, 64'd52,               64'd0,                 64'h0000_0000_F234_5678, 1'b0, 5};
      vecs[7]  = '{1'b0, 3'b010, 64'd51,               64'd0,                 64'h0000_0000_3456_7892, 1'b0, 5};
      vecs[8]  = '{1'b0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0,              64'h0807_0605_0403_0201, 1'b0, 9};
      vecs[9]  = '{1'b1, 3'b011, 64'd40,   64'h1122_3344_5566_7788,           64'd0,                 1'b0, 9};
      vecs[10] = '{1'b0, 3'b011, 64'd40,               64'd0,                 64'h1122_3344_5566_7788, 1'b0, 9};
      vecs[11] = '{1'b1, 3'b000, 64'd60,   64'h0000_0000_0000_00AB,           64'd0,                 1'b0, 2};
      vecs[12] = '{1'b0, 3'b000, 64'd60,               64'd0,                 64'hFFFF_FFFF_FFFF_FFAB, 1'b0, 2};
      vecs[13] = '{1'b1, 3'b001, 64'd62,   64'h0000_DEAD_BEEF_CAFE,           64'd0,                 1'b0, 3};
      vecs[14] = '{1'b0, 3'b101, 64'd62,               64'd0,                 64'h0000_0000_0000_CAFE, 1'b0, 3};
      vecs[15] = '{1'b0, 3'b100, 64'd64,               64'd0,                 64'd0,                 1'b0, 2};
      vecs[16] = '{1'b1, 3'b100, 64'd40,   64'hFFFF_FFFF_FFFF_FFFF,           64'd0,                 1'b1, 1};
      vecs[17] = '{1'b0, 3'b111, 64'd20,               64'd0,                 64'd0,                 1'b1, 1};
      vecs[18] = '{1'b1, 3'b110, 64'd40,   64'hFFFF_FFFF_FFFF_FFFF,           64'd0,                 1'b1, 1};
      vecs[19] = '{1'b0, 3'b011, 64'd40,               64'd0,                 64'h1122_3344_5566_7788, 1'b0, 9};

      reset = 1'b0;
      preload = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr = '0;
      bus.req_wdata = '0;
      @(negedge clk);
      @(negedge clk);
      preload = 1'b0;
      chk("rst_ready", 0, 64'(bus.req_ready), 64'd1);
      chk("rst_resp",  0, 64'(bus.resp_valid | bus.resp_err), 64'd0);
      chk("rst_rdata", 0, bus.resp_rdata, 64'd0);
      chk("rst_mem",   0, 64'(bus.mem_we | bus.mem_re), 64'd0);
      chk("rst_addr",  0, bus.mem_addr, 64'd0);
      chk("rst_wdata", 0, 64'(bus.mem_wdata), 64'd0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 20; i++) run(i, vecs[i]);

      // Reset during a store: three bytes land, the fourth is cut off.
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_funct3 = 3'b011;
      bus.req_addr = 64'd40;
      bus.req_wdata = 64'hA1A2_A3A4_A5A6_A7A8;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("abort_pre_we", 0, 64'(bus.mem_we), 64'd1);
      reset = 1'b0;
      #1;
      chk("abort_we",    0, 64'(bus.mem_we), 64'd0);
      chk("abort_ready", 0, 64'(bus.req_ready), 64'd1);
      chk("abort_resp",  0, 64'(bus.resp_valid), 64'd0);
      chk("abort_addr",  0, bus.mem_addr, 64'd0);
      @(negedge clk);
      @(negedge clk);
      chk("abort_rdata", 0, bus.resp_rdata, 64'd0);
      exp_bytes = '{8'hA8, 8'hA7, 8'hA6, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
      for (int i = 0; i < 8; i++) chk("abort_mem", 40 + i, 64'(mem[40 + i]), 64'(exp_bytes[i]));
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_resp",  i, 64'(bus.resp_valid), 64'd0);
         chk("post_rst_ready", i, 64'(bus.req_ready), 64'd1);
      end
      fin = '{1'b0, 3'b011, 64'd40, 64'd0, 64'h1122_3344_55A6_A7A8, 1'b0, 9};
      run(20, fin);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
